// File: rtl/edge_gen_pkg.sv
`default_nettype none
// ============================================================================
// Package  : edge_gen_pkg
// Brief    : Shared sizing helpers for the edge generator slice.
// Revision : 1.0 - initial release
// ============================================================================
package edge_gen_pkg;

    // Bits needed to hold a phase timer counting down from hold_cyc-1.
    function automatic int unsigned hold_timer_width(input int unsigned hold_cyc);
        return (hold_cyc < 1) ? 1 : $clog2(hold_cyc + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dffr.sv
`default_nettype none
// ============================================================================
// Module   : dffr
// Brief    : D flip-flop bank with asynchronous active-low reset to zero.
// Revision : 1.0 - initial release
// ============================================================================
module dffr #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/edge_gen_updown_cnt.sv
`default_nettype none
// ============================================================================
// Module   : updown_cnt
// Brief    : Saturating up/down counter with synchronous clear and a
//            registered overflow pulse for increments refused at full scale.
// Revision : 1.0 - initial release
// ============================================================================
module updown_cnt #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_ovf
);

    localparam logic [WIDTH-1:0] c_max = '1;
    localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

    logic [WIDTH-1:0] r_cnt;
    logic             r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= 1'b0;
            if (i_clr) begin
                r_cnt <= '0;
            end else if (i_inc && !i_dec) begin
                if (r_cnt == c_max) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + c_one;
                end
            end else if (i_dec && !i_inc && (r_cnt != '0)) begin
                r_cnt <= r_cnt - c_one;
            end
        end
    end

    assign o_cnt = r_cnt;
    assign o_ovf = r_ovf;

endmodule
`default_nettype wire

// File: rtl/edge_gen.sv
`default_nettype none
// ============================================================================
// Module   : edge_gen
// Brief    : Turns single-cycle requests into pulses whose high and low levels
//            each last HOLD_CYC cycles; excess requests queue in a counter.
// Revision : 1.0 - initial release
// ============================================================================
module edge_gen
    import edge_gen_pkg::*;
#(
    parameter int unsigned HOLD_CYC  = 4,
    parameter int unsigned CNT_WIDTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 req_i,
    input  logic                 clr_i,
    output logic                 dat_o,
    output logic                 busy_o,
    output logic [CNT_WIDTH-1:0] pend_o,
    output logic                 done_o,
    output logic                 drop_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } state_t;

    localparam int unsigned         c_tw   = hold_timer_width(HOLD_CYC);
    localparam logic [c_tw-1:0]     c_load = c_tw'(HOLD_CYC - 1);
    localparam logic [c_tw-1:0]     c_one  = c_tw'(1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [c_tw-1:0] r_timer;
    logic [c_tw-1:0] w_timer_nxt;
    logic            w_done;
    logic            w_timer_zero;
    logic            w_launch_pt;
    logic            w_pend_nz;
    logic            w_req;
    logic            w_launch_pend;
    logic            w_launch_direct;
    logic            w_inc;
    logic            w_dat_nxt;

    // A new pulse may start from IDLE or at the end of the guard-low phase;
    // clear suppresses both queued and direct launches in that cycle.
    assign w_timer_zero    = (r_timer == '0);
    assign w_launch_pt     = (r_state == S_IDLE) || ((r_state == S_LOW) && w_timer_zero);
    assign w_pend_nz       = |pend_o;
    assign w_req           = req_i & ~clr_i;
    assign w_launch_pend   = w_launch_pt & w_pend_nz & ~clr_i;
    assign w_launch_direct = w_launch_pt & ~w_pend_nz & w_req;
    assign w_inc           = w_req & ~w_launch_direct;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_done      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_launch_pend || w_launch_direct) begin
                    w_state_nxt = S_HIGH;
                end
            end
            S_HIGH: begin
                if (w_timer_zero) begin
                    w_state_nxt = S_LOW;
                end
            end
            S_LOW: begin
                if (w_timer_zero) begin
                    w_done      = 1'b1;
                    w_state_nxt = (w_launch_pend || w_launch_direct) ? S_HIGH : S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // Every phase entry reloads the timer; IDLE parks it at zero.
        if (!w_timer_zero) begin
            w_timer_nxt = r_timer - c_one;
        end else if (w_state_nxt != S_IDLE) begin
            w_timer_nxt = c_load;
        end else begin
            w_timer_nxt = '0;
        end
    end

    assign w_dat_nxt = (w_state_nxt == S_HIGH);

    dffr #(
        .WIDTH (1)
    ) u_dat_reg (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .i_d   (w_dat_nxt),
        .o_q   (dat_o)
    );

    updown_cnt #(
        .WIDTH (CNT_WIDTH)
    ) u_pend_cnt (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .i_clr (clr_i),
        .i_inc (w_inc),
        .i_dec (w_launch_pend),
        .o_cnt (pend_o),
        .o_ovf (drop_o)
    );

    assign busy_o = (r_state != S_IDLE);
    assign done_o = w_done;

endmodule
`default_nettype wire
